pc_fetch_unit: RTL

Program-counter register and instruction-fetch sequencer for the RISC-V core. It holds the current PC and drives it to the PC+4 adder, which returns pc_plus4. It issues requests to instruction memory with a req/ready, rvalid handshake and presents the fetched instruction and its PC to decode. It also handles decode stall, branch/jump redirect with flush, and discard of in-flight responses.

---
 rtl/pc_fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: REQ -> WAIT -> output register; rvalid to if_valid in 1 cycle.
// Stall parks a word in a one-entry skid (HOLD). MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic        kill;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] redir_pc;
  logic        redir_mis;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc_o;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    redir_mis = (redirect_target[1:0] != 2'b00);
    redir_pc  = redir_mis ? TRAP_VECTOR : redirect_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_trap <= 1'b0;
    else        misalign_trap <= redirect_valid && redir_mis;
  end
`else
  always_comb begin
    redir_mis = 1'b0;
    redir_pc  = redirect_target & ~32'h0000_0003;
  end

  assign misalign_trap = redir_mis;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_o       <= RESET_VECTOR;
      kill       <= 1'b0;
      skid_instr <= NOP;
      skid_pc    <= 32'h0;
      if_valid   <= 1'b0;
      if_instr   <= NOP;
      if_pc      <= 32'h0;
    end else if (redirect_valid) begin
      pc_o     <= redir_pc;
      if_valid <= 1'b0;
      case (state)
        REQ: begin
          kill  <= imem_ready;
          state <= imem_ready ? WAIT : REQ;
        end
        WAIT: begin
          // A response landing with the redirect is dropped right here; otherwise kill the pending one.
          kill  <= !imem_rvalid;
          state <= imem_rvalid ? REQ : WAIT;
        end
        default: begin
          kill  <= 1'b0;
          state <= REQ;
        end
      endcase
    end else begin
      if (if_valid && !stall) if_valid <= 1'b0;
      case (state)
        BOOT: state <= REQ;
        REQ:  if (imem_ready) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else if (!if_valid || !stall) begin
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc    <= pc_o;
              pc_o     <= pc_plus4;
              state    <= REQ;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc_o;
              pc_o       <= pc_plus4;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            state    <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
